uart_apb_ctrl: RTL and testbench
================================

# uart_apb_ctrl

APB slave that configures and sequences the UART datapath: it owns the baud divisor fed to `baud_gen`, pushes transmit bytes into the TX FIFO, pops received bytes from the RX FIFO, and tracks RX overrun and the interrupt. It sits between the APB bus and the `baud_gen`/`receiver`/`fifo` instances inside the UART top level.

## Interface
- DIVSR_RESET, 650: divisor reset value (9600 baud at 100 MHz, 16x oversampling)
- DIVSR_W, 11: divisor width, matching `baud_gen.divsr`
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- psel, penable, pwrite  in  1  APB control
- paddr  in  4  byte address; word-aligned registers only
- pwdata  in  32  APB write data
- prdata  out  32  APB read data
- pready  out  1  APB ready
- pslverr  out  1  APB error; valid with pready
- divsr  out  DIVSR_W  divisor to `baud_gen`
- tx_wr_en  out  1  one-cycle TX FIFO push strobe
- tx_data  out  8  TX FIFO write data
- tx_full  in  1  TX FIFO full
- rx_rd_en  out  1  one-cycle RX FIFO pop strobe
- rx_data  in  8  RX FIFO head data; valid the cycle after rx_rd_en
- rx_empty, rx_full  in  1  RX FIFO flags
- rx_done_tick  in  1  `receiver` byte-complete strobe (FIFO write enable)
- irq  out  1  level interrupt, registered

## Operation
- Register map: 0x0 DATA (W: push TX, R: pop RX), 0x4 STATUS, 0x8 CTRL, 0xC DIVSR.
- STATUS: bit0 rx_empty, bit1 rx_full, bit2 tx_full (live, RO); bit3 overrun (sticky, W1C); other bits read 0.
- CTRL: bit0 rx_ie, bit1 ovr_ie; other bits read 0, writes ignored.
- DIVSR: bits[10:0] R/W; writing 0 → pslverr, value kept; new value drives `divsr` the next cycle.
- FSM states IDLE, RD_WAIT, RESP:
  - IDLE: on psel&penable → decode. DATA read with !rx_empty → assert rx_rd_en (one cycle), go RD_WAIT, pready=0. All other accesses complete this cycle (pready=1).
  - RD_WAIT: capture rx_data into prdata[7:0], upper bits 0, go RESP.
  - RESP: pready=1, pslverr=0, return to IDLE.
- DATA write with !tx_full → tx_wr_en=1, tx_data=pwdata[7:0], same cycle as pready. With tx_full → pslverr=1, no push.
- DATA read with rx_empty → prdata=0, pslverr=1, no pop, zero wait.
- paddr[1:0]≠0 → pslverr=1, no side effect.
- Overrun set: rx_done_tick & rx_full & !rx_rd_en. Set beats a same-cycle W1C clear.
- irq = (rx_ie & !rx_empty) | (ovr_ie & overrun), registered.

## Timing
- Reset: prdata=0, pready=0, pslverr=0, divsr=DIVSR_RESET, tx_wr_en=0, rx_rd_en=0, CTRL=0, overrun=0, irq=0, FSM=IDLE.
- pready is 0 outside access phases; only asserts with psel&penable.
- Register/write access: 0 wait states. RX pop: 2 wait states (pready in third access cycle).
- Strobes tx_wr_en/rx_rd_en are exactly one cycle per APB transfer.
- Reset mid-RD_WAIT: pending pop dropped; popped byte lost (allowed).
- psel dropped mid-transfer (protocol violation): FSM completes to IDLE, no extra strobe.
- irq lags status changes by one cycle.

## Configuration
- UART_APB_CTRL_IRQ_EN defined: CTRL register, overrun-to-irq path and irq output as above.
- Undefined: irq tied 0, CTRL reads 0 and writes are ignored without error; overrun bit still tracked in STATUS.

## Structure
- Package `uart_pkg`: register offsets, STATUS/CTRL bit indices, DIVSR_RESET, FSM state enum.
- Single module; no sub-module warranted.

## Test plan
- Reset release, read 0xC → prdata=650, pslverr=0; write 0x145 then read → 0x145; write 0 → pslverr=1, still 0x145.
- Write 0x0 with pwdata=0xA5, tx_full=0 → tx_wr_en one cycle, tx_data=0xA5; repeat with tx_full=1 → pslverr=1, no strobe.
- Receive 0x55 into RX FIFO, read 0x0 → rx_rd_en one cycle, pready after 2 wait states, prdata=0x55; read again empty → prdata=0, pslverr=1.
- Fill RX FIFO, send one more frame → STATUS bit3=1; write 0x8 to STATUS → cleared; clear coincident with new overrun → stays 1.
- CTRL=0x1, receive byte → irq=1 one cycle after rx_empty falls; pop → irq=0; with macro undefined irq stays 0.
- Read 0x2 → pslverr=1, no strobes; assert rst_n low during RD_WAIT → all outputs at reset values immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART APB control block: register word offsets,
// STATUS/CTRL bit positions, divisor defaults and the APB sequencing states.
// -----------------------------------------------------------------------------
package uart_pkg;

   // Divisor defaults: 650 gives 9600 baud from 100 MHz with 16x oversampling.
   localparam int unsigned DIVSR_W_DEF     = 11;
   localparam int unsigned DIVSR_RESET_DEF = 650;

   // Register byte offsets.
   localparam logic [3:0] ADDR_DATA   = 4'h0;
   localparam logic [3:0] ADDR_STATUS = 4'h4;
   localparam logic [3:0] ADDR_CTRL   = 4'h8;
   localparam logic [3:0] ADDR_DIVSR  = 4'hC;

   // Register select taken from paddr[3:2].
   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_DIVSR  = 2'd3
   } reg_sel_e;

   // STATUS bit positions.
   localparam int unsigned STAT_RX_EMPTY = 0;
   localparam int unsigned STAT_RX_FULL  = 1;
   localparam int unsigned STAT_TX_FULL  = 2;
   localparam int unsigned STAT_OVERRUN  = 3;

   // CTRL bit positions.
   localparam int unsigned CTRL_RX_IE  = 0;
   localparam int unsigned CTRL_OVR_IE = 1;

   // APB sequencing states.
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_RD_WAIT = 2'd1,
      ST_RESP    = 2'd2
   } state_e;

endpackage

// File: rtl/uart_apb_ctrl.sv
// -----------------------------------------------------------------------------
// uart_apb_ctrl
// APB slave that owns the baud divisor, pushes TX bytes, pops RX bytes
// (two wait states), tracks sticky RX overrun and drives a registered irq.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   psel, penable, pwrite, paddr,
//   pwdata                         APB request
//   prdata, pready, pslverr        APB response
//   divsr                          divisor to baud_gen
//   tx_wr_en, tx_data, tx_full     TX FIFO push side
//   rx_rd_en, rx_data, rx_empty,
//   rx_full, rx_done_tick          RX FIFO pop side and receiver strobe
//   irq                            registered level interrupt
//
// Build option: define UART_APB_CTRL_IRQ_EN to enable the CTRL register and
// the irq output; otherwise CTRL reads 0, writes are ignored and irq is 0.
// -----------------------------------------------------------------------------
module uart_apb_ctrl
   import uart_pkg::*;
#(
   parameter int unsigned DIVSR_W     = DIVSR_W_DEF,
   parameter int unsigned DIVSR_RESET = DIVSR_RESET_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               psel,
   input  logic               penable,
   input  logic               pwrite,
   input  logic [3:0]         paddr,
   input  logic [31:0]        pwdata,
   output logic [31:0]        prdata,
   output logic               pready,
   output logic               pslverr,
   output logic [DIVSR_W-1:0] divsr,
   output logic               tx_wr_en,
   output logic [7:0]         tx_data,
   input  logic               tx_full,
   output logic               rx_rd_en,
   input  logic [7:0]         rx_data,
   input  logic               rx_empty,
   input  logic               rx_full,
   input  logic               rx_done_tick,
   output logic               irq
);

   state_e               state_q, state_d;
   logic [DIVSR_W-1:0]   divsr_q;
   logic                 overrun_q;
   logic [7:0]           rx_byte_q;
   logic                 irq_q, irq_d;
   logic                 divsr_we, ovr_clr, ovr_set;
   logic                 access, aligned;
   reg_sel_e             reg_sel;
   logic                 unused_bits;

   // Gating with rst_n keeps every combinational output at its reset value
   // while reset is held, even if the bus is mid-access.
   assign access      = psel & penable & rst_n;
   assign aligned     = (paddr[1:0] == 2'b00);
   assign reg_sel     = reg_sel_e'(paddr[3:2]);
   assign unused_bits = ^pwdata[31:DIVSR_W];

`ifdef UART_APB_CTRL_IRQ_EN
   logic [1:0] ctrl_q;
   logic       ctrl_we;
`endif

   // NOTE: every signal driven here gets a default first so no path infers a latch.
   always_comb begin
      state_d  = state_q;
      pready   = 1'b0;
      pslverr  = 1'b0;
      prdata   = '0;
      tx_wr_en = 1'b0;
      tx_data  = '0;
      rx_rd_en = 1'b0;
      divsr_we = 1'b0;
      ovr_clr  = 1'b0;
`ifdef UART_APB_CTRL_IRQ_EN
      ctrl_we  = 1'b0;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (access) begin
               pready = 1'b1;
               if (!aligned) begin
                  pslverr = 1'b1;
               end else begin
                  unique case (reg_sel)
                     REG_DATA: begin
                        if (pwrite) begin
                           if (tx_full) begin
                              pslverr = 1'b1;
                           end else begin
                              tx_wr_en = 1'b1;
                              tx_data  = pwdata[7:0];
                           end
                        end else if (rx_empty) begin
                           pslverr = 1'b1;
                        end else begin
                           // Pop now; head byte is valid next cycle.
                           rx_rd_en = 1'b1;
                           pready   = 1'b0;
                           state_d  = ST_RD_WAIT;
                        end
                     end
                     REG_STATUS: begin
                        if (pwrite) begin
                           ovr_clr = pwdata[STAT_OVERRUN];
                        end else begin
                           prdata[STAT_RX_EMPTY] = rx_empty;
                           prdata[STAT_RX_FULL]  = rx_full;
                           prdata[STAT_TX_FULL]  = tx_full;
                           prdata[STAT_OVERRUN]  = overrun_q;
                        end
                     end
                     REG_CTRL: begin
`ifdef UART_APB_CTRL_IRQ_EN
                        if (pwrite) ctrl_we = 1'b1;
                        else        prdata[1:0] = ctrl_q;
`endif
                     end
                     REG_DIVSR: begin
                        if (pwrite) begin
                           // Zero would stall baud_gen: reject and keep the old value.
                           if (pwdata[DIVSR_W-1:0] == '0) pslverr  = 1'b1;
                           else                           divsr_we = 1'b1;
                        end else begin
                           prdata[DIVSR_W-1:0] = divsr_q;
                        end
                     end
                     default: ;
                  endcase
               end
            end
         end
         ST_RD_WAIT: state_d = ST_RESP;
         ST_RESP: begin
            // Completes to IDLE even if the master dropped psel mid-transfer.
            state_d     = ST_IDLE;
            pready      = access;
            prdata[7:0] = rx_byte_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // A byte arriving into a full FIFO is lost unless a pop frees space this cycle.
   assign ovr_set = rx_done_tick & rx_full & ~rx_rd_en;

`ifdef UART_APB_CTRL_IRQ_EN
   assign irq_d = (ctrl_q[CTRL_RX_IE] & ~rx_empty) | (ctrl_q[CTRL_OVR_IE] & overrun_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       ctrl_q <= '0;
      else if (ctrl_we) ctrl_q <= pwdata[1:0];
   end
`else
   assign irq_d = 1'b0;
`endif

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         divsr_q   <= DIVSR_W'(DIVSR_RESET);
         overrun_q <= 1'b0;
         rx_byte_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         state_q <= state_d;
         irq_q   <= irq_d;
         if (divsr_we)               divsr_q   <= pwdata[DIVSR_W-1:0];
         if (state_q == ST_RD_WAIT)  rx_byte_q <= rx_data;
         // Set wins over a coincident write-1-to-clear.
         if (ovr_set)                overrun_q <= 1'b1;
         else if (ovr_clr)           overrun_q <= 1'b0;
      end
   end

   assign divsr = divsr_q;
   assign irq   = irq_q;

endmodule

// File: tb/tb_uart_apb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_apb_ctrl
// Self-checking bench for uart_apb_ctrl: directed register scenarios with
// literal expectations, then randomized APB traffic and FIFO flags checked
// every cycle against a transaction-level model of the register map.
// -----------------------------------------------------------------------------
module tb_uart_apb_ctrl;

`ifdef UART_APB_CTRL_IRQ_EN
   localparam bit IRQ_EN = 1'b1;
`else
   localparam bit IRQ_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        psel, penable, pwrite;
   logic [3:0]  paddr;
   logic [31:0] pwdata, prdata;
   logic        pready, pslverr;
   logic [10:0] divsr;
   logic        tx_wr_en, tx_full, rx_rd_en;
   logic [7:0]  tx_data, rx_data;
   logic        rx_empty, rx_full, rx_done_tick, irq;

   uart_apb_ctrl dut (
      .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
      .divsr(divsr), .tx_wr_en(tx_wr_en), .tx_data(tx_data), .tx_full(tx_full),
      .rx_rd_en(rx_rd_en), .rx_data(rx_data), .rx_empty(rx_empty), .rx_full(rx_full),
      .rx_done_tick(rx_done_tick), .irq(irq)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- behavioural model ----------------
   int unsigned m_divsr;
   bit          m_ovr;
   bit [1:0]    m_ctrl;
   bit          m_irq;
   int          m_wait;      // cycles left in a pending pop: 2 = byte in flight, 1 = respond
   bit [7:0]    m_byte;

   bit          exp_pready, exp_pslverr, exp_tx_wr_en, exp_rx_rd_en;
   logic [31:0] exp_prdata;
   logic [7:0]  exp_tx_data;
   bit          cmp_en = 1'b0;

   task automatic model_reset();
      m_divsr = 650; m_ovr = 0; m_ctrl = 0; m_irq = 0; m_wait = 0; m_byte = 0;
   endtask

   // Expected outputs for the current cycle from register-map rules.
   task automatic model_eval();
      bit acc;
      acc = psel && penable;
      exp_pready = 0; exp_pslverr = 0; exp_tx_wr_en = 0; exp_rx_rd_en = 0;
      exp_prdata = 0; exp_tx_data = 0;
      if (m_wait == 1) begin
         exp_pready = acc;
         exp_prdata = {24'h0, m_byte};
      end else if (m_wait == 0 && acc) begin
         exp_pready = 1;
         if (paddr[1:0] != 2'b00) exp_pslverr = 1;
         else case (paddr)
            4'h0: if (pwrite) begin
                     if (tx_full) exp_pslverr = 1;
                     else begin exp_tx_wr_en = 1; exp_tx_data = pwdata[7:0]; end
                  end else if (rx_empty) exp_pslverr = 1;
                  else begin exp_rx_rd_en = 1; exp_pready = 0; end
            4'h4: if (!pwrite) exp_prdata = {28'h0, m_ovr, tx_full, rx_full, rx_empty};
            4'h8: if (!pwrite) exp_prdata = IRQ_EN ? {30'h0, m_ctrl} : 32'h0;
            default: if (pwrite) exp_pslverr = (pwdata[10:0] == 11'h0);
                     else exp_prdata = m_divsr;
         endcase
      end
   endtask

   // State advance at the clock edge, using the inputs of the cycle just ended.
   task automatic model_commit();
      bit acc, reg_wr, set, clr, nirq;
      acc    = psel && penable;
      reg_wr = (m_wait == 0) && acc && pwrite;
      set    = rx_done_tick && rx_full && !exp_rx_rd_en;
      clr    = reg_wr && paddr == 4'h4 && pwdata[3];
      nirq   = IRQ_EN && ((m_ctrl[0] && !rx_empty) || (m_ctrl[1] && m_ovr));
      if (reg_wr && paddr == 4'hC && pwdata[10:0] != 0) m_divsr = pwdata[10:0];
      if (reg_wr && paddr == 4'h8 && IRQ_EN) m_ctrl = pwdata[1:0];
      if (m_wait == 2) m_byte = rx_data;
      if (m_wait > 0) m_wait--;
      else if (exp_rx_rd_en) m_wait = 2;
      m_ovr = set || (m_ovr && !clr);
      m_irq = nirq;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (cmp_en && rst_n) begin
         check("pready", pready, exp_pready);
         if (exp_pready) check("pslverr", pslverr, exp_pslverr);
         if (exp_pready && !pwrite) check("prdata", prdata, exp_prdata);
         check("tx_wr_en", tx_wr_en, exp_tx_wr_en);
         if (exp_tx_wr_en) check("tx_data", tx_data, exp_tx_data);
         check("rx_rd_en", rx_rd_en, exp_rx_rd_en);
         check("divsr", divsr, m_divsr);
         check("irq", irq, m_irq);
      end
   end

   // ---------------- drivers ----------------
   bit          rand_flags = 0;
   logic [31:0] s_prdata;
   logic        s_pslverr, s_pready, s_irq;
   logic [7:0]  s_tx_data;
   int          obs_tx, obs_rx;

   task automatic shake();
      tx_full      = ($urandom_range(0, 3) == 0);
      rx_empty     = ($urandom_range(0, 2) == 0);
      rx_full      = !rx_empty && ($urandom_range(0, 3) == 0);
      rx_done_tick = ($urandom_range(0, 3) == 0);
      rx_data      = 8'($urandom);
   endtask

   task automatic step();
      model_eval();
      @(negedge clk);
      s_prdata = prdata; s_pslverr = pslverr; s_pready = pready; s_irq = irq;
      if (tx_wr_en) begin obs_tx++; s_tx_data = tx_data; end
      if (rx_rd_en) obs_rx++;
      @(posedge clk);
      model_commit();
      #1;
   endtask

   task automatic apb(input bit wr, input logic [3:0] addr, input logic [31:0] data,
                      output logic [31:0] rdata, output logic err, output int cycles);
      bit done;
      obs_tx = 0; obs_rx = 0; done = 0; cycles = 0; rdata = 0; err = 0;
      psel = 1; penable = 0; pwrite = wr; paddr = addr; pwdata = data;
      if (rand_flags) shake();
      step();
      penable = 1;
      for (int n = 0; n < 8 && !done; n++) begin
         if (rand_flags) shake();
         step();
         cycles++;
         if (s_pready) begin done = 1; rdata = s_prdata; err = s_pslverr; end
      end
      check("apb_done", done, 1);
      psel = 0; penable = 0;
   endtask

   logic [31:0] rd;
   logic        er;
   int          cyc;
   bit          r_wr;
   logic [3:0]  r_addr;
   logic [31:0] r_data;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0;
      tx_full = 0; rx_empty = 1; rx_full = 0; rx_done_tick = 0; rx_data = 0;
      model_reset();
      #12;
      check("rst_prdata", prdata, 0);
      check("rst_pready", pready, 0);
      check("rst_pslverr", pslverr, 0);
      check("rst_divsr", divsr, 650);
      check("rst_strobes", {tx_wr_en, rx_rd_en}, 0);
      check("rst_irq", irq, 0);
      @(negedge clk) rst_n = 1;
      @(posedge clk) #1;
      cmp_en = 1;

      // Divisor register
      apb(0, 4'hC, 0, rd, er, cyc);      check("divsr_rst_rd", rd, 650); check("divsr_rst_err", er, 0);
      apb(1, 4'hC, 32'h145, rd, er, cyc); check("divsr_wr_err", er, 0);
      apb(0, 4'hC, 0, rd, er, cyc);      check("divsr_rd", rd, 32'h145);
      apb(1, 4'hC, 0, rd, er, cyc);      check("divsr_zero_err", er, 1);
      apb(0, 4'hC, 0, rd, er, cyc);      check("divsr_kept", rd, 32'h145);

      // TX push
      apb(1, 4'h0, 32'hA5, rd, er, cyc);
      check("tx_err", er, 0); check("tx_strobes", obs_tx, 1); check("tx_byte", s_tx_data, 8'hA5);
      tx_full = 1;
      apb(1, 4'h0, 32'h5A, rd, er, cyc);
      check("tx_full_err", er, 1); check("tx_full_nostrobe", obs_tx, 0);
      tx_full = 0;

      // RX pop with two wait states, then empty read
      rx_empty = 0; rx_data = 8'h55;
      apb(0, 4'h0, 0, rd, er, cyc);
      check("rx_data", rd, 32'h55); check("rx_err", er, 0);
      check("rx_strobes", obs_rx, 1); check("rx_access_cycles", cyc, 3);
      rx_empty = 1;
      apb(0, 4'h0, 0, rd, er, cyc);
      check("rx_empty_data", rd, 0); check("rx_empty_err", er, 1);
      check("rx_empty_nostrobe", obs_rx, 0); check("rx_empty_cycles", cyc, 1);

      // Overrun: set, W1C, set beating a coincident clear
      rx_empty = 0; rx_full = 1; rx_done_tick = 1;
      step();
      rx_done_tick = 0;
      apb(0, 4'h4, 0, rd, er, cyc);         check("ovr_set", rd, 32'h0A);
      apb(1, 4'h4, 32'h8, rd, er, cyc);
      apb(0, 4'h4, 0, rd, er, cyc);         check("ovr_clr", rd, 32'h02);
      rx_done_tick = 1;
      apb(1, 4'h4, 32'h8, rd, er, cyc);
      rx_done_tick = 0;
      apb(0, 4'h4, 0, rd, er, cyc);         check("ovr_set_beats_clr", rd, 32'h0A);
      apb(1, 4'h4, 32'h8, rd, er, cyc);
      rx_full = 0; rx_empty = 1;
      apb(0, 4'h4, 0, rd, er, cyc);         check("ovr_clr2", rd, 32'h01);

      // Interrupt on RX not empty
      apb(1, 4'h8, 32'h1, rd, er, cyc);     check("ctrl_wr_err", er, 0);
      apb(0, 4'h8, 0, rd, er, cyc);         check("ctrl_rd", rd, IRQ_EN ? 32'h1 : 32'h0);
      rx_empty = 0;
      step();                               check("irq_lag", s_irq, 0);
      step();                               check("irq_on", s_irq, IRQ_EN);
      rx_data = 8'h3C;
      apb(0, 4'h0, 0, rd, er, cyc);         check("irq_pop", rd, 32'h3C);
      rx_empty = 1;
      step();                               check("irq_hold", s_irq, IRQ_EN);
      step();                               check("irq_off", s_irq, 0);
      apb(1, 4'h8, 32'h0, rd, er, cyc);

      // Unaligned access
      apb(0, 4'h2, 0, rd, er, cyc);
      check("unaligned_err", er, 1); check("unaligned_nostrobe", obs_tx + obs_rx, 0);

      // psel dropped during a pop: one strobe only, FSM drains
      rx_empty = 0; rx_data = 8'h77; obs_rx = 0; obs_tx = 0;
      psel = 1; penable = 0; pwrite = 0; paddr = 4'h0;
      step();
      penable = 1;
      step();
      psel = 0; penable = 0;
      repeat (3) step();
      check("drop_one_strobe", obs_rx, 1);
      apb(0, 4'h0, 0, rd, er, cyc);         check("drop_recover", rd, 32'h77);

      // Reset while the pop is in flight
      apb(1, 4'hC, 32'h123, rd, er, cyc);
      psel = 1; penable = 0; pwrite = 0; paddr = 4'h0;
      step();
      penable = 1;
      step();
      cmp_en = 0;
      rst_n = 0;
      #1;
      check("midrst_pready", pready, 0);
      check("midrst_pslverr", pslverr, 0);
      check("midrst_prdata", prdata, 0);
      check("midrst_strobes", {tx_wr_en, rx_rd_en}, 0);
      check("midrst_divsr", divsr, 650);
      check("midrst_irq", irq, 0);
      psel = 0; penable = 0; rx_empty = 1; rx_done_tick = 0;
      model_reset();
      @(negedge clk) rst_n = 1;
      @(posedge clk) #1;
      cmp_en = 1;
      apb(0, 4'hC, 0, rd, er, cyc);         check("post_rst_divsr", rd, 650);

      // Randomized traffic
      rand_flags = 1;
      for (int t = 0; t < 400; t++) begin
         r_wr   = 1'($urandom_range(0, 1));
         r_addr = {2'($urandom_range(0, 3)), 2'b00};
         if ($urandom_range(0, 7) == 0) r_addr = 4'($urandom_range(0, 15));
         r_data = $urandom;
         if ($urandom_range(0, 3) == 0) r_data[10:0] = 11'h0;
         apb(r_wr, r_addr, r_data, rd, er, cyc);
         repeat ($urandom_range(0, 2)) begin
            shake();
            step();
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
